// File: rtl/multicore_pkg.sv
// Shared sizing for the multicore I/O arbiter: core count, data and request widths,
// plus the core index type used on both the sample and result paths.
package multicore_pkg;

    localparam int N_CORES = 43;
    localparam int DATA_W  = 31;
    localparam int REQ_W   = 4;
    localparam int ID_W    = $clog2(N_CORES);

    typedef logic [ID_W-1:0]   core_id_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/multicore_io_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at a registered pointer, which
// moves to winner+1 (wrapping) only on cycles where a grant is actually taken.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    gnt_onehot,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   idx;

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        idx        = '0;
        // One extra bit on idx keeps ptr+i from overflowing before the wrap.
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N)) begin
                idx = idx - (ID_W+1)'(N);
            end
            if (!any && req[idx[ID_W-1:0]]) begin
                any    = 1'b1;
                gnt_id = idx[ID_W-1:0];
            end
        end
        gnt_onehot[gnt_id] = any;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && any) begin
            ptr <= (gnt_id == ID_W'(N-1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/multicore_io_arbiter.sv
// Shares one ADC sample stream and one result sink among N_CORES cores: round-robin
// sample grants on the input side, per-core holding buffers drained round-robin on output.
module multicore_io_arbiter
    import multicore_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CORES*REQ_W-1:0]    core_req,
    output logic [N_CORES-1:0]          core_in_gnt,
    output logic [DATA_W-1:0]           core_in_data,
    input  logic                        adc_valid,
    input  logic [DATA_W-1:0]           adc_data,
    output logic                        adc_pop,
    input  logic [N_CORES*REQ_W-1:0]    core_out_en,
    input  logic [N_CORES*DATA_W-1:0]   core_out_data,
    output logic [N_CORES-1:0]          core_out_ack,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [ID_W-1:0]             out_core_id,
    input  logic                        out_ready,
    output logic                        overflow
);

    logic [N_CORES-1:0] req_nz, en_nz, eligible, in_onehot;
    logic [N_CORES-1:0] buf_full, dr_onehot, drain_sel, capture, drop;
    core_id_t           in_id_unused, dr_id;
    logic               in_any, dr_any, load;
    data_t              buf_data [N_CORES];

    always_comb begin
        req_nz = '0;
        en_nz  = '0;
        for (int i = 0; i < N_CORES; i++) begin
            req_nz[i] = |core_req[i*REQ_W +: REQ_W];
            en_nz[i]  = |core_out_en[i*REQ_W +: REQ_W];
        end
    end

    // A core granted last edge is masked so a held level request is not served twice.
    assign eligible = req_nz & ~core_in_gnt;

    rr_arbiter #(.N(N_CORES), .ID_W(ID_W)) u_in_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (eligible),
        .advance    (adc_valid),
        .gnt_onehot (in_onehot),
        .gnt_id     (in_id_unused),
        .any        (in_any)
    );

    // Gated by rst_n: no sample may be consumed while the grant register is held in reset.
    assign adc_pop = rst_n & adc_valid & in_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in_gnt  <= '0;
            core_in_data <= '0;
        end else if (adc_pop) begin
            core_in_gnt  <= in_onehot;
            core_in_data <= adc_data;
        end else begin
            core_in_gnt  <= '0;
        end
    end

    assign load = ~out_valid | out_ready;

    rr_arbiter #(.N(N_CORES), .ID_W(ID_W)) u_drain_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (buf_full),
        .advance    (load),
        .gnt_onehot (dr_onehot),
        .gnt_id     (dr_id),
        .any        (dr_any)
    );

    // A slot being drained this cycle is free for a new result on the same edge.
    assign drain_sel = load ? dr_onehot : '0;
    assign capture   = en_nz & (~buf_full | drain_sel);
    assign drop      = en_nz & buf_full & ~drain_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full     <= '0;
            core_out_ack <= '0;
            overflow     <= 1'b0;
        end else begin
            buf_full     <= (buf_full & ~drain_sel) | capture;
            core_out_ack <= capture;
            if (|drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: buffer payload has no reset; buf_full alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CORES; i++) begin
            if (capture[i]) begin
                buf_data[i] <= core_out_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_core_id <= '0;
        end else if (load) begin
            out_valid <= dr_any;
            if (dr_any) begin
                out_data    <= buf_data[dr_id];
                out_core_id <= dr_id;
            end
        end
    end

endmodule

// File: tb/tb_multicore_io_arbiter.sv
// Directed bench for multicore_io_arbiter: grants and drained results are scored
// against queues of expected items filled as stimulus is driven.
module tb_multicore_io_arbiter;
    import multicore_pkg::*;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } item_t;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [N_CORES*REQ_W-1:0]    core_req;
    logic [N_CORES-1:0]          core_in_gnt;
    logic [DATA_W-1:0]           core_in_data;
    logic                        adc_valid;
    logic [DATA_W-1:0]           adc_data;
    logic                        adc_pop;
    logic [N_CORES*REQ_W-1:0]    core_out_en;
    logic [N_CORES*DATA_W-1:0]   core_out_data;
    logic [N_CORES-1:0]          core_out_ack;
    logic                        out_valid;
    logic [DATA_W-1:0]           out_data;
    logic [ID_W-1:0]             out_core_id;
    logic                        out_ready;
    logic                        overflow;

    int    total = 0;
    int    bad   = 0;
    item_t in_q[$];
    item_t out_q[$];

    multicore_io_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .core_req      (core_req),
        .core_in_gnt   (core_in_gnt),
        .core_in_data  (core_in_data),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .adc_pop       (adc_pop),
        .core_out_en   (core_out_en),
        .core_out_data (core_out_data),
        .core_out_ack  (core_out_ack),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_core_id   (out_core_id),
        .out_ready     (out_ready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] d(input int v);
        return DATA_W'(v);
    endfunction

    function automatic logic [N_CORES-1:0] bit_of(input int i);
        logic [N_CORES-1:0] m;
        m    = '0;
        m[i] = 1'b1;
        return m;
    endfunction

    function automatic item_t mk(input int id, input logic [DATA_W-1:0] v);
        item_t it;
        it.id   = ID_W'(id);
        it.data = v;
        return it;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [REQ_W-1:0] v);
        core_req[id*REQ_W +: REQ_W] = v;
    endtask

    task automatic set_en(input int id, input logic [REQ_W-1:0] v, input logic [DATA_W-1:0] data);
        core_out_en[id*REQ_W +: REQ_W]     = v;
        core_out_data[id*DATA_W +: DATA_W] = data;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_in_gnt"},   core_in_gnt,  '0);
        check({pfx, "_in_data"},  core_in_data, '0);
        check({pfx, "_adc_pop"},  adc_pop,      '0);
        check({pfx, "_ack"},      core_out_ack, '0);
        check({pfx, "_out_valid"}, out_valid,   '0);
        check({pfx, "_out_data"}, out_data,     '0);
        check({pfx, "_out_id"},   out_core_id,  '0);
        check({pfx, "_overflow"}, overflow,     '0);
    endtask

    // One input-side cycle: drive ADC, check the combinational pop, record the expected grant.
    task automatic in_step(input logic v, input logic [DATA_W-1:0] data, input logic exp_pop, input int id);
        adc_valid = v;
        adc_data  = data;
        #1;
        check("adc_pop", adc_pop, exp_pop);
        if (exp_pop) in_q.push_back(mk(id, data));
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        if (rst_n) begin
            if (core_in_gnt != '0) begin
                if (in_q.size() == 0) begin
                    check("in_gnt_spurious", core_in_gnt, '0);
                end else begin
                    it = in_q.pop_front();
                    check("in_gnt", core_in_gnt, bit_of(int'(it.id)));
                    check("in_data", core_in_data, it.data);
                end
            end
            if (out_valid && out_ready) begin
                if (out_q.size() == 0) begin
                    check("out_spurious", out_valid, 1'b0);
                end else begin
                    it = out_q.pop_front();
                    check("out_id", out_core_id, it.id);
                    check("out_data", out_data, it.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b1;
        core_req      = '0;
        core_out_en   = '0;
        core_out_data = '0;
        adc_valid     = 1'b0;
        adc_data      = '0;
        out_ready     = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("rst0");
        tick();
        tick();
        rst_n = 1'b1;

        // Reset in the middle of traffic; after release the lowest requester wins.
        set_req(20, 4'h1);
        set_req(10, 4'h2);
        in_step(1'b1, d(100), 1'b1, 10);
        @(negedge clk);
        #1;
        adc_data = d(200);
        rst_n    = 1'b0;
        #1 check_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        in_step(1'b1, d(300), 1'b1, 10);
        core_req  = '0;
        adc_valid = 1'b0;
        tick();

        // Three held requesters served in rotation, one sample per cycle.
        do_reset();
        set_req(3, 4'h1);
        set_req(7, 4'h8);
        set_req(42, 4'hF);
        in_step(1'b1, d(10),  1'b1, 3);
        in_step(1'b1, d(-20), 1'b1, 7);
        in_step(1'b1, d(30),  1'b1, 42);
        in_step(1'b1, d(40),  1'b1, 3);
        core_req = '0;

        // A single held requester is granted only every other cycle.
        set_req(5, 4'h4);
        in_step(1'b1, d(51), 1'b1, 5);
        in_step(1'b1, d(52), 1'b0, 0);
        check("mask_gnt_idle", core_in_gnt, '0);
        check("mask_data_hold", core_in_data, d(51));
        in_step(1'b1, d(53), 1'b1, 5);
        in_step(1'b1, d(54), 1'b0, 0);
        core_req = '0;

        // No ADC data: nothing granted and the pointer (now 6) stays put, so 40 beats 2.
        set_req(2, 4'h1);
        set_req(40, 4'h3);
        in_step(1'b0, d(60), 1'b0, 0);
        check("noadc_gnt", core_in_gnt, '0);
        in_step(1'b0, d(60), 1'b0, 0);
        in_step(1'b1, d(61), 1'b1, 40);
        in_step(1'b1, d(62), 1'b1, 2);
        core_req  = '0;
        adc_valid = 1'b0;
        tick();

        // Two results in the same cycle: acks at t+1, outputs at t+2 and t+3.
        out_ready = 1'b1;
        set_en(0, 4'h1, d(-1));
        set_en(1, 4'h9, d(7));
        out_q.push_back(mk(0, d(-1)));
        out_q.push_back(mk(1, d(7)));
        tick();
        core_out_en = '0;
        check("res_ack", core_out_ack, bit_of(0) | bit_of(1));
        check("res_valid_t1", out_valid, 1'b0);
        tick();
        check("res_valid_t2", out_valid, 1'b1);
        check("res_id_t2", out_core_id, 0);
        tick();
        check("res_valid_t3", out_valid, 1'b1);
        check("res_id_t3", out_core_id, 1);
        tick();
        check("res_valid_t4", out_valid, 1'b0);
        check("res_ack_t4", core_out_ack, '0);

        // Stalled sink: core 9 occupies the output, core 2's second result is dropped.
        out_ready = 1'b0;
        set_en(9, 4'h1, d(900));
        out_q.push_back(mk(9, d(900)));
        tick();
        core_out_en = '0;
        check("stall_ack9", core_out_ack, bit_of(9));
        tick();
        check("stall_valid", out_valid, 1'b1);
        check("stall_id9", out_core_id, 9);
        set_en(2, 4'h1, d(222));
        out_q.push_back(mk(2, d(222)));
        tick();
        core_out_en = '0;
        check("stall_ack2", core_out_ack, bit_of(2));
        check("stall_ovf0", overflow, 1'b0);
        set_en(2, 4'h2, d(333));
        tick();
        core_out_en = '0;
        check("drop_ovf", overflow, 1'b1);
        check("drop_noack", core_out_ack, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_hold_valid", out_valid, 1'b1);
            check("stall_hold_id", out_core_id, 9);
            check("stall_hold_data", out_data, d(900));
        end
        out_ready = 1'b1;
        tick();
        check("rel_valid", out_valid, 1'b1);
        check("rel_id", out_core_id, 2);
        check("rel_data", out_data, d(222));
        tick();
        check("rel_done", out_valid, 1'b0);
        tick();
        check("rel_idle", out_valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        check("in_q_empty", in_q.size(), 0);
        check("out_q_empty", out_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
